// File: rtl/uart_rx_param.sv
// rtl/uart_rx_param.sv - oversampling UART receiver with parity/framing/break detection and FWFT receive FIFO
module uart_rx_param #(
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 1,
    parameter int STOP_BITS  = 1,
    parameter int OVERSAMPLE = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int RTS_LEVEL  = FIFO_DEPTH - 1
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic                 Rx_In,
    input  logic                 Rd_En,
    output logic                 RTS,
    output logic                 Data_Rdy_Out,
    output logic [DATA_BITS-1:0] Rx_Data_Out,
    output logic [2:0]           Rx_Error,
    output logic                 Overrun
);
    localparam int SW = $clog2(OVERSAMPLE);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int EW = DATA_BITS + 3;
    localparam logic [CW-1:0] RTS_LVL   = CW'(RTS_LEVEL);
    localparam logic [CW-1:0] FULL_LVL  = CW'(FIFO_DEPTH);
    localparam logic          PAR_ODD   = (PARITY == 2);
    localparam logic          PAR_EN    = (PARITY != 0);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK_WAIT
    } state_t;

    state_t                 state_q, state_d;
    logic                   sync1_q, sync2_q;
    logic [SW-1:0]          scnt_q, scnt_d;
    logic [3:0]             bcnt_q, bcnt_d;
    logic [DATA_BITS-1:0]   data_q, data_d;
    logic                   par_q, par_d;
    logic                   ferr_q, ferr_d;
    logic                   zero_q, zero_d;
    logic [EW-1:0]          mem_q [FIFO_DEPTH];
    logic [PW-1:0]          wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   rts_q, rts_d;
    logic                   ovr_q, ovr_d;

    logic          rx_s, tick, half, last_data, last_stop;
    logic          push, brk, frame_err, par_err;
    logic          pop, full, wr_en;
    logic [EW-1:0] entry, head;

    assign rx_s      = sync2_q;
    assign tick      = (scnt_q == SW'(OVERSAMPLE - 1));
    assign half      = (scnt_q == SW'(OVERSAMPLE / 2 - 1));
    assign last_data = (bcnt_q == 4'(DATA_BITS - 1));
    assign last_stop = (bcnt_q == 4'(STOP_BITS - 1));
    // Break/framing include the stop sample being taken this cycle.
    assign brk       = zero_q & ~rx_s;
    assign frame_err = ferr_q | ~rx_s | brk;
    assign par_err   = PAR_EN && ((^data_q ^ par_q) != PAR_ODD);

    always_ff @(posedge Clk) begin
        if (Rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            state_q <= S_IDLE;
            scnt_q  <= '0;
            bcnt_q  <= '0;
            data_q  <= '0;
            par_q   <= 1'b0;
            ferr_q  <= 1'b0;
            zero_q  <= 1'b1;
            wptr_q  <= '0;
            rptr_q  <= '0;
            cnt_q   <= '0;
            rts_q   <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            sync1_q <= Rx_In;
            sync2_q <= sync1_q;
            state_q <= state_d;
            scnt_q  <= scnt_d;
            bcnt_q  <= bcnt_d;
            data_q  <= data_d;
            par_q   <= par_d;
            ferr_q  <= ferr_d;
            zero_q  <= zero_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            cnt_q   <= cnt_d;
            rts_q   <= rts_d;
            ovr_q   <= ovr_d;
        end
    end

    always_ff @(posedge Clk) begin
        if (wr_en) mem_q[wptr_q] <= entry;
    end

    always_comb begin
        state_d = state_q;
        scnt_d  = scnt_q + 1'b1;
        bcnt_d  = bcnt_q;
        data_d  = data_q;
        par_d   = par_q;
        ferr_d  = ferr_q;
        zero_d  = zero_q;
        case (state_q)
            S_IDLE: begin
                scnt_d = '0;
                bcnt_d = '0;
                ferr_d = 1'b0;
                zero_d = 1'b1;
                par_d  = 1'b0;
                if (!rx_s) state_d = S_START;
            end
            S_START: begin
                if (half) begin
                    scnt_d  = '0;
                    state_d = rx_s ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (tick) begin
                    scnt_d = '0;
                    data_d = {rx_s, data_q[DATA_BITS-1:1]};
                    zero_d = zero_q & ~rx_s;
                    if (last_data) begin
                        bcnt_d  = '0;
                        state_d = PAR_EN ? S_PARITY : S_STOP;
                    end else begin
                        bcnt_d = bcnt_q + 4'd1;
                    end
                end
            end
            S_PARITY: begin
                if (tick) begin
                    scnt_d  = '0;
                    par_d   = rx_s;
                    zero_d  = zero_q & ~rx_s;
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (tick) begin
                    scnt_d = '0;
                    ferr_d = ferr_q | ~rx_s;
                    zero_d = zero_q & ~rx_s;
                    if (last_stop) state_d = brk ? S_BREAK_WAIT : S_IDLE;
                    else           bcnt_d  = bcnt_q + 4'd1;
                end
            end
            S_BREAK_WAIT: begin
                scnt_d = '0;
                if (rx_s) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        push  = (state_q == S_STOP) && tick && last_stop;
        entry = {brk, frame_err, par_err, data_q};
        pop   = Rd_En && (cnt_q != '0);
        full  = (cnt_q == FULL_LVL);
        // When full, a simultaneous pop frees the head slot that the write reuses.
        wr_en  = push && (!full || pop);
        ovr_d  = push && full && !pop;
        wptr_d = wptr_q + PW'(wr_en);
        rptr_d = rptr_q + PW'(pop);
        cnt_d  = cnt_q + CW'(wr_en) - CW'(pop);
        rts_d  = (cnt_d < RTS_LVL);
        head   = mem_q[rptr_q];
    end

    assign RTS          = rts_q;
    assign Overrun      = ovr_q;
    assign Data_Rdy_Out = (cnt_q != '0);
    assign Rx_Data_Out  = Data_Rdy_Out ? head[DATA_BITS-1:0] : '0;
    assign Rx_Error     = Data_Rdy_Out ? head[EW-1:DATA_BITS] : 3'b000;
endmodule

// File: tb/tb_uart_rx_param.sv
// tb/tb_uart_rx_param.sv - scoreboard bench for uart_rx_param at default parameters
module tb_uart_rx_param;
    logic       Clk = 1'b0;
    logic       Rst = 1'b1;
    logic       Rx_In = 1'b1;
    logic       Rd_En = 1'b0;
    logic       RTS, Data_Rdy_Out, Overrun;
    logic [7:0] Rx_Data_Out;
    logic [2:0] Rx_Error;

    int          checks = 0;
    int          errors = 0;
    int          ovr_cnt = 0;
    bit          auto_read = 1'b0;
    logic [10:0] exp_q[$];

    uart_rx_param dut (
        .Clk(Clk), .Rst(Rst), .Rx_In(Rx_In), .Rd_En(Rd_En),
        .RTS(RTS), .Data_Rdy_Out(Data_Rdy_Out), .Rx_Data_Out(Rx_Data_Out),
        .Rx_Error(Rx_Error), .Overrun(Overrun)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic hold(input logic v, input int n);
        Rx_In = v;
        repeat (n) @(negedge Clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic p, input logic s);
        hold(1'b0, 16);
        for (int i = 0; i < 8; i++) hold(d[i], 16);
        hold(p, 16);
        hold(s, 16);
        hold(1'b1, 32);
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < 3000) begin
            @(negedge Clk);
            k++;
        end
        check("drain", exp_q.size(), 0);
        repeat (4) @(negedge Clk);
    endtask

    initial begin
        forever begin
            @(negedge Clk);
            Rd_En = auto_read && Data_Rdy_Out && !Rst;
        end
    end

    // Monitor: every popped entry is matched against the scoreboard head.
    initial begin
        logic [10:0] e;
        forever begin
            @(negedge Clk);
            #1;
            if (Overrun === 1'b1) ovr_cnt++;
            if (Rd_En && Data_Rdy_Out) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_entry: got %0h expected none", {Rx_Error, Rx_Data_Out});
                end else begin
                    e = exp_q.pop_front();
                    if ({Rx_Error, Rx_Data_Out} !== e) begin
                        errors++;
                        $display("FAIL entry: got err=%b data=%0h expected err=%b data=%0h",
                                 Rx_Error, Rx_Data_Out, e[10:8], e[7:0]);
                    end
                end
            end
        end
    end

    initial begin
        repeat (3) @(negedge Clk);
        check("rst_rts", RTS, 0);
        check("rst_rdy", Data_Rdy_Out, 0);
        check("rst_data", Rx_Data_Out, 0);
        check("rst_err", Rx_Error, 0);
        check("rst_ovr", Overrun, 0);
        Rst = 1'b0;
        @(negedge Clk);
        check("rts_after_rst", RTS, 1);
        auto_read = 1'b1;

        exp_q.push_back({3'b000, 8'hA5}); send_frame(8'hA5, 1'b0, 1'b1);
        exp_q.push_back({3'b001, 8'h01}); send_frame(8'h01, 1'b0, 1'b1);
        exp_q.push_back({3'b010, 8'h3C}); send_frame(8'h3C, 1'b0, 1'b0);
        exp_q.push_back({3'b000, 8'h5A}); send_frame(8'h5A, 1'b0, 1'b1);
        exp_q.push_back({3'b110, 8'h00}); hold(1'b0, 192); hold(1'b1, 32);
        exp_q.push_back({3'b000, 8'h81}); send_frame(8'h81, 1'b0, 1'b1);
        drain();
        check("rdy_after_read", Data_Rdy_Out, 0);

        hold(1'b0, 3); hold(1'b1, 40);
        check("glitch_no_entry", Data_Rdy_Out, 0);
        drain();

        auto_read = 1'b0;
        repeat (2) @(negedge Clk);
        exp_q.push_back({3'b000, 8'h10}); send_frame(8'h10, 1'b1, 1'b1);
        exp_q.push_back({3'b000, 8'h11}); send_frame(8'h11, 1'b0, 1'b1);
        check("rts_2_entries", RTS, 1);
        exp_q.push_back({3'b000, 8'h12}); send_frame(8'h12, 1'b0, 1'b1);
        check("rts_3_entries", RTS, 0);
        exp_q.push_back({3'b000, 8'h13}); send_frame(8'h13, 1'b1, 1'b1);
        check("no_overrun_4", ovr_cnt, 0);
        send_frame(8'h14, 1'b0, 1'b1);
        check("overrun_5", ovr_cnt, 1);
        check("rdy_full", Data_Rdy_Out, 1);
        auto_read = 1'b1;
        drain();
        check("rts_empty", RTS, 1);

        hold(1'b0, 16); hold(1'b1, 16); hold(1'b0, 16); hold(1'b1, 16);
        Rst = 1'b1;
        repeat (2) @(negedge Clk);
        Rx_In = 1'b1;
        Rst = 1'b0;
        hold(1'b1, 40);
        check("rst_mid_frame", Data_Rdy_Out, 0);
        exp_q.push_back({3'b000, 8'h66}); send_frame(8'h66, 1'b0, 1'b1);
        drain();
        check("overrun_total", ovr_cnt, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/uart_rx_param.md
UART_RX_PARAM -- requirements
Module: uart_rx_param

Interface
REQ-001 Parameter DATA_BITS, default 8, data bits per frame, legal 5..9.
REQ-002 Parameter PARITY, default 1, parity mode: 0 none, 1 even, 2 odd.
REQ-003 Parameter STOP_BITS, default 1, stop bits per frame, legal 1 or 2.
REQ-004 Parameter OVERSAMPLE, default 16, clocks per bit, even, >=4.
REQ-005 Parameter FIFO_DEPTH, default 4, receive FIFO entries, power of 2, >=2.
REQ-006 Parameter RTS_LEVEL, default FIFO_DEPTH-1, occupancy at which RTS deasserts.
REQ-007 Clk  input  1  single clock; all logic on rising edge.
REQ-008 Rst  input  1  reset; synchronous and active-high.
REQ-009 Rx_In  input  1  asynchronous serial line, idle high.
REQ-010 Rd_En  input  1  pop FIFO head this cycle.
REQ-011 RTS  output  1  1 = receiver can accept frames.
REQ-012 Data_Rdy_Out  output  1  FIFO not empty.
REQ-013 Rx_Data_Out  output  DATA_BITS  FIFO head data; 0 when empty.
REQ-014 Rx_Error  output  3  head error flags: [0] parity, [1] framing, [2] break; 0 when empty.
REQ-015 Overrun  output  1  one-cycle pulse: completed frame dropped, FIFO full.

Function
REQ-016 Rx_In passes a 2-flop synchroniser (reset value 1); all decisions use the synchronised value.
REQ-017 States: IDLE, START, DATA, PARITY, STOP, BREAK_WAIT; bit counter and sample counter (0..OVERSAMPLE-1).
REQ-018 IDLE: synchronised line 0 -> START, sample counter cleared.
REQ-019 START: at count OVERSAMPLE/2-1 line 0 -> DATA; line 1 -> IDLE (glitch, nothing pushed).
REQ-020 Every later bit sampled once, exactly OVERSAMPLE clocks after the previous sample (mid-bit).
REQ-021 DATA: DATA_BITS samples, LSB first; then PARITY if PARITY!=0, else STOP.
REQ-022 Parity error = PARITY!=0 and (XOR of data and parity bit) != (PARITY==2); PARITY=0 -> always 0.
REQ-023 STOP: STOP_BITS samples; framing error if any stop sample is 0.
REQ-024 Break error = all data, parity (if present) and stop samples 0; break also sets framing.
REQ-025 On last stop sample: push {errors, data} to FIFO; next state BREAK_WAIT if break else IDLE.
REQ-026 BREAK_WAIT: stay until synchronised line 1, then IDLE; no start detection meanwhile.
REQ-027 Data_Rdy_Out, Rx_Data_Out, Rx_Error valid the cycle after the push (first-word fall-through).
REQ-028 Rd_En with FIFO empty ignored; pointers wrap modulo FIFO_DEPTH.
REQ-029 Push when full and no pop: frame discarded, FIFO unchanged, Overrun=1 for one cycle.
REQ-030 Push and Rd_En same cycle when full: pop then push; no Overrun; occupancy unchanged.
REQ-031 RTS registered: 1 when occupancy < RTS_LEVEL, else 0; receiver keeps receiving when RTS=0.
REQ-032 Parity/framing/break errors never block FIFO push; errors travel with their data entry.

Reset
REQ-033 Rst=1 on a clock edge: state IDLE, counters 0, FIFO empty, synchroniser 1s.
REQ-034 Outputs during/after reset: RTS=0 while Rst=1, 1 the first cycle after; Data_Rdy_Out, Rx_Data_Out, Rx_Error, Overrun = 0.
REQ-035 Reset mid-frame abandons the frame; no push; FIFO contents lost.

Verification (defaults; bit time 16 clocks)
REQ-036 Frame 0xA5, parity 0, stop 1 -> Data_Rdy_Out=1, Rx_Data_Out=0xA5, Rx_Error=000; Rd_En -> Data_Rdy_Out=0.
REQ-037 Frame 0x01, parity 0 (wrong) -> Rx_Data_Out=0x01, Rx_Error=001.
REQ-038 Frame 0x3C, parity 0, stop 0, then line high -> Rx_Error=010, next frame received normally.
REQ-039 Line low 12 bit times then high -> one entry 0x00, Rx_Error=110; no second entry; frame after line high accepted.
REQ-040 Idle line low 3 clocks -> no entry; 5 frames 0x10..0x14 without reads -> RTS 0 after 3rd, Overrun pulse on 5th, pops give 0x10..0x13.
REQ-041 Rst asserted mid-DATA of 0x55 -> no entry; next full frame 0x66 received correctly, Rx_Error=000.
